// File: rtl/multirate_v1_mul_pipe.sv
// Pipelined signed x unsigned multiplier with round-half-up right shift and a global-stall handshake.
// Define MULTIRATE_MUL_SAT_EN to saturate out-of-range results; otherwise they wrap to DOUT_WIDTH bits.
module multirate_v1_mul_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 17,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int P        = DIN0_WIDTH + DIN1_WIDTH;
  localparam int RW       = P + 1;
  localparam int EW       = (RW > DOUT_WIDTH) ? RW : DOUT_WIDTH;
  localparam int HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] HALF = (SHIFT > 0) ? (RW'(1) << HALF_POS) : '0;

  // One spare bit above the product keeps the rounding add from overflowing.
  function automatic logic [DOUT_WIDTH:0] finish_fn(input logic [P-1:0] prod);
    logic signed [RW-1:0]   rnd;
    logic signed [EW-1:0]   ext;
    logic [EW-DOUT_WIDTH:0] top;
    logic                   over;
    logic [DOUT_WIDTH-1:0]  res;
    rnd  = {prod[P-1], prod};
    rnd  = $signed(rnd + HALF) >>> SHIFT;
    ext  = EW'(rnd);
    top  = ext[EW-1:DOUT_WIDTH-1];
    over = !((&top) || !(|top));
    res  = ext[DOUT_WIDTH-1:0];
`ifdef MULTIRATE_MUL_SAT_EN
    if (over) begin
      res = ext[EW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
`endif
    return {over, res};
  endfunction

  logic [P-1:0]          a_ext;
  logic [P-1:0]          b_ext;
  logic [P-1:0]          prod_in;
  logic [P-1:0]          prod_last;
  logic [NUM_STAGE-1:0]  vld_q;
  logic                  valid_last;
  logic                  adv;
  logic [DOUT_WIDTH:0]   fin;

  // Low P bits of the two's-complement product are exact since the true result fits in P bits.
  assign a_ext   = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext   = {{DIN0_WIDTH{1'b0}}, din1};
  assign prod_in = a_ext * b_ext;

  assign out_valid = vld_q[NUM_STAGE-1];
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_single
      assign prod_last  = prod_in;
      assign valid_last = in_valid;
    end else begin : g_multi
      logic [P-1:0] prod_q [NUM_STAGE-1];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) begin
            prod_q[i] <= '0;
          end
        end else if (adv) begin
          prod_q[0] <= prod_in;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            prod_q[i] <= prod_q[i-1];
          end
        end
      end

      assign prod_last  = prod_q[NUM_STAGE-2];
      assign valid_last = vld_q[NUM_STAGE-2];
    end
  endgenerate

  assign fin = finish_fn(prod_last);

  // Overflow is flagged as a valid result enters the output stage; a new set beats ovf_clr.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else begin
      if (adv) begin
        dout <= fin[DOUT_WIDTH-1:0];
      end
      if (adv && valid_last && fin[DOUT_WIDTH]) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multirate_v1_mul_pipe.sv
// Self-checking bench for multirate_v1_mul_pipe: directed cases on a default and a SHIFT=4 instance,
// then a randomized sweep of NUM_STAGE 1..4 against an arithmetic reference model.
module tb_multirate_v1_mul_pipe;

  localparam int MAIN_NS = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [15:0] din0      = '0;
  logic [16:0] din1      = '0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic        ovf_clr   = 1'b0;

  logic        in_ready, out_valid, ovf;
  logic [31:0] dout;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [31:0] s_dout;
  logic [3:0]  sw_rdy, sw_vld, sw_ovf;
  logic [31:0] sw_dout [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multirate_v1_mul_pipe u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  multirate_v1_mul_pipe #(.SHIFT(4)) u_shift (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
    .in_valid(in_valid), .in_ready(s_in_ready), .dout(s_dout), .out_valid(s_out_valid),
    .out_ready(out_ready), .ovf(s_ovf), .ovf_clr(ovf_clr)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    multirate_v1_mul_pipe #(.NUM_STAGE(g + 1)) u_sw (
      .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1),
      .in_valid(in_valid), .in_ready(sw_rdy[g]), .dout(sw_dout[g]), .out_valid(sw_vld[g]),
      .out_ready(out_ready), .ovf(sw_ovf[g]), .ovf_clr(ovf_clr)
    );
  end

  // Reference: exact product, round half up by adding half an LSB and flooring, then fit to 32 bits.
  function automatic logic [32:0] model(input longint a, input longint b, input int shift);
    longint      v;
    longint      hi;
    longint      lo;
    logic        o;
    logic [31:0] r;
    v = a * b;
    if (shift > 0) v = (v + (longint'(1) <<< (shift - 1))) >>> shift;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    o  = (v > hi) || (v < lo);
    r  = v[31:0];
`ifdef MULTIRATE_MUL_SAT_EN
    if (v > hi) r = 32'h7FFF_FFFF;
    else if (v < lo) r = 32'h8000_0000;
`endif
    return {o, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [16:0] b, input logic v);
    din0     = a;
    din1     = b;
    in_valid = v;
  endtask

  // Presents one operand pair for one cycle and returns how many cycles later out_valid showed up.
  task automatic sendAndWait(input logic [15:0] a, input logic [16:0] b, output int lat);
    applyStimulus(a, b, 1'b1);
    @(negedge clk);
    checkOutput("accept_in_ready", {63'd0, in_ready}, 64'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 10);
  endtask

  task automatic checkMain(input string tag, input logic [15:0] a, input logic [16:0] b, input int lat);
    logic [32:0] m;
    logic [32:0] ms;
    m  = model(longint'($signed(a)), longint'(b), 0);
    ms = model(longint'($signed(a)), longint'(b), 4);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(MAIN_NS));
    checkOutput({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, "_dout"}, {32'd0, dout}, {32'd0, m[31:0]});
    checkOutput({tag, "_svalid"}, {63'd0, s_out_valid}, 64'd1);
    checkOutput({tag, "_sready"}, {63'd0, s_in_ready}, 64'd1);
    checkOutput({tag, "_sdout"}, {32'd0, s_dout}, {32'd0, ms[31:0]});
  endtask

  initial begin
    int          lat;
    int          nin;
    int          nout;
    logic        stalled_prev;
    logic [31:0] held;
    logic [32:0] exp_res [256];
    int          acc_cyc [256];
    int          wr;
    int          rd [4];
    logic        expov [4];

    $display("[TB] start");
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_dout", {32'd0, dout}, 64'd0);
    checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    sendAndWait(16'hFFFD, 17'd5, lat);
    checkMain("m3x5", 16'hFFFD, 17'd5, lat);
    checkOutput("m3x5_const", {32'd0, dout}, {32'd0, 32'hFFFF_FFF1});
    checkOutput("m3x5_ovf", {63'd0, ovf}, 64'd0);

    @(posedge clk);
    #1;
    sendAndWait(16'h8000, 17'h1FFFF, lat);
    checkMain("ovfcase", 16'h8000, 17'h1FFFF, lat);
`ifdef MULTIRATE_MUL_SAT_EN
    checkOutput("ovfcase_const", {32'd0, dout}, {32'd0, 32'h8000_0000});
`else
    checkOutput("ovfcase_const", {32'd0, dout}, {32'd0, 32'h0000_8000});
`endif
    checkOutput("ovfcase_flag", {63'd0, ovf}, 64'd1);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared", {63'd0, ovf}, 64'd0);

    // ovf_clr lands on the same edge the overflowing result reaches the output stage.
    @(posedge clk);
    #1 applyStimulus(16'h8000, 17'h1FFFF, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("set_wins_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("set_wins_ovf", {63'd0, ovf}, 64'd1);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared2", {63'd0, ovf}, 64'd0);

    @(posedge clk);
    #1;
    sendAndWait(16'd25, 17'd1, lat);
    checkMain("p25", 16'd25, 17'd1, lat);
    checkOutput("shift_pos", {32'd0, s_dout}, 64'd2);
    @(posedge clk);
    #1;
    sendAndWait(16'hFFE7, 17'd1, lat);
    checkMain("n25", 16'hFFE7, 17'd1, lat);
    checkOutput("shift_neg", {32'd0, s_dout}, {32'd0, 32'hFFFF_FFFE});
    checkOutput("shift_ovf", {63'd0, s_ovf}, 64'd0);

    // Stream 1..5 with a three-cycle downstream stall in the middle.
    @(posedge clk);
    #1;
    nin = 0;
    nout = 0;
    stalled_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && nout < 5; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (nin < 5) applyStimulus(16'(nin + 1), 17'd2, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (!out_ready) begin
        checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      if (stalled_prev) checkOutput("stall_hold", {32'd0, dout}, {32'd0, held});
      if (out_valid && out_ready) begin
        checkOutput("stream_order", {32'd0, dout}, 64'(2 * (nout + 1)));
        nout++;
      end
      if (in_valid && in_ready) nin++;
      stalled_prev = out_valid && !out_ready;
      held = dout;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    checkOutput("stream_count", 64'(nout), 64'd5);

    // Reset with two operands in flight.
    applyStimulus(16'd7, 17'd3, 1'b1);
    @(posedge clk);
    #1 applyStimulus(16'd9, 17'd4, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_rst_dout", {32'd0, dout}, 64'd0);
    checkOutput("async_rst_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(16'd11, 17'd1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rst_no_capture", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    sendAndWait(16'd5, 17'd6, lat);
    checkMain("post_rst", 16'd5, 17'd6, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Random sweep across NUM_STAGE 1..4 with random bubbles.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    wr = 0;
    for (int g = 0; g < 4; g++) begin
      rd[g] = 0;
      expov[g] = 1'b0;
    end
    for (int c = 0; c < 120; c++) begin
      if (c < 100 && $urandom_range(0, 3) != 0) applyStimulus(16'($urandom), 17'($urandom), 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        checkOutput($sformatf("sweep%0d_in_ready", g + 1), {63'd0, sw_rdy[g]}, 64'd1);
        if (sw_vld[g]) begin
          if (rd[g] < wr) begin
            checkOutput($sformatf("sweep%0d_dout", g + 1), {32'd0, sw_dout[g]}, {32'd0, exp_res[rd[g]][31:0]});
            checkOutput($sformatf("sweep%0d_lat", g + 1), 64'(c - acc_cyc[rd[g]]), 64'(g + 1));
            expov[g] = expov[g] | exp_res[rd[g]][32];
            checkOutput($sformatf("sweep%0d_ovf", g + 1), {63'd0, sw_ovf[g]}, {63'd0, expov[g]});
            rd[g]++;
          end else begin
            checkOutput($sformatf("sweep%0d_spurious", g + 1), {63'd0, sw_vld[g]}, 64'd0);
          end
        end
      end
      if (in_valid) begin
        exp_res[wr] = model(longint'($signed(din0)), longint'(din1), 0);
        acc_cyc[wr] = c;
        wr++;
      end
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("sweep%0d_drained", g + 1), 64'(rd[g]), 64'(wr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
